// File: rtl/input_debounce.sv
// Two-flop synchroniser plus debouncer for push-buttons (per-bit FSM) and slide switches (shared window).
// Define LONG_PRESS_EN to enable the one-shot BTN_LONG hold pulse; otherwise BTN_LONG is tied low.
module input_debounce #(
   parameter int N_BTN       = 5,
   parameter int N_SW        = 16,
   parameter int DB_CYCLES   = 1000000,
   parameter int CNT_W       = 20,
   parameter int LONG_CYCLES = 100000000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_BTN-1:0] BTN_RAW,
   input  logic [N_SW-1:0]  SW_RAW,
   output logic [N_BTN-1:0] BTN_LEVEL,
   output logic [N_BTN-1:0] BTN_PRESS,
   output logic [N_BTN-1:0] BTN_RELEASE,
   output logic [N_BTN-1:0] BTN_LONG,
   output logic [N_SW-1:0]  SW_OUT,
   output logic             SW_CHANGED
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DB_PRE  = CNT_W'(DB_CYCLES - 2);
`ifdef LONG_PRESS_EN
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
`endif

   if (DB_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_cfg
      $error("input_debounce: DB_CYCLES must be >= 2 and LONG_CYCLES >= 1");
   end

   typedef enum logic [1:0] {IDLE, P_WAIT, PRESSED, R_WAIT} btn_state_t;

   logic [N_BTN-1:0] btn_s0, btn_s1;
   logic [N_SW-1:0]  sw_s0, sw_s1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         btn_s0 <= '0;
         btn_s1 <= '0;
         sw_s0  <= '0;
         sw_s1  <= '0;
      end else begin
         btn_s0 <= BTN_RAW;
         btn_s1 <= btn_s0;
         sw_s0  <= SW_RAW;
         sw_s1  <= sw_s0;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_state_t       state, state_nx;
      logic [CNT_W-1:0] cnt, cnt_nx;
      logic             level, level_nx, press, press_nx, rel, rel_nx;
`ifdef LONG_PRESS_EN
      logic             lng, lng_nx;
`endif

      always_comb begin
         state_nx = state;
         cnt_nx   = cnt;
         level_nx = level;
         press_nx = 1'b0;
         rel_nx   = 1'b0;
`ifdef LONG_PRESS_EN
         lng_nx   = 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (btn_s1[i]) begin
                  state_nx = P_WAIT;
                  cnt_nx   = CNT_ONE;
               end
            end
            P_WAIT: begin
               if (!btn_s1[i]) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (cnt == DB_LAST) begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
                  level_nx = 1'b1;
                  press_nx = 1'b1;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!btn_s1[i]) begin
                  state_nx = R_WAIT;
                  cnt_nx   = CNT_ONE;
               end
`ifdef LONG_PRESS_EN
               // Saturating at LONG_CYCLES makes the pulse one-shot until the count is cleared.
               else begin
                  if (cnt != LONG_SAT) cnt_nx = cnt + CNT_ONE;
                  lng_nx = (cnt == LONG_LAST);
               end
`endif
            end
            R_WAIT: begin
               if (btn_s1[i]) begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
               end else if (cnt == DB_LAST) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
                  level_nx = 1'b0;
                  rel_nx   = 1'b1;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
               level_nx = 1'b0;
            end
         endcase
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
`ifdef LONG_PRESS_EN
            lng   <= 1'b0;
`endif
         end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            press <= press_nx;
            rel   <= rel_nx;
`ifdef LONG_PRESS_EN
            lng   <= lng_nx;
`endif
         end
      end

      assign BTN_LEVEL[i]   = level;
      assign BTN_PRESS[i]   = press;
      assign BTN_RELEASE[i] = rel;
`ifdef LONG_PRESS_EN
      assign BTN_LONG[i]    = lng;
`else
      assign BTN_LONG[i]    = 1'b0;
`endif
   end

   logic [N_SW-1:0]  sw_cap;
   logic [CNT_W-1:0] sw_cnt;

   // Any change restarts the shared window, so flips inside one window merge into one update.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sw_cap     <= '0;
         sw_cnt     <= '0;
         SW_OUT     <= '0;
         SW_CHANGED <= 1'b0;
      end else begin
         SW_CHANGED <= 1'b0;
         if (sw_s1 != sw_cap) begin
            sw_cap <= sw_s1;
            sw_cnt <= '0;
         end else if (sw_cnt != DB_LAST) begin
            sw_cnt <= sw_cnt + CNT_ONE;
            if (sw_cnt == DB_PRE && sw_cap != SW_OUT) begin
               SW_OUT     <= sw_cap;
               SW_CHANGED <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: expected pulses are queued with their due cycle and
// matched by a negedge monitor; level/state checks are immediate assertions.
module tb_input_debounce;

   localparam int N_BTN = 5;
   localparam int N_SW  = 16;
   localparam int DB    = 4;
   localparam int LONG  = 20;
   localparam int LAT   = 2 + DB;

   logic             CLK = 1'b0;
   logic             RST;
   logic [N_BTN-1:0] BTN_RAW;
   logic [N_SW-1:0]  SW_RAW;
   logic [N_BTN-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;
   logic [N_SW-1:0]  SW_OUT;
   logic             SW_CHANGED;

   input_debounce #(
      .N_BTN(N_BTN), .N_SW(N_SW), .DB_CYCLES(DB), .CNT_W(20), .LONG_CYCLES(LONG)
   ) dut (
      .CLK(CLK), .RST(RST), .BTN_RAW(BTN_RAW), .SW_RAW(SW_RAW),
      .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE),
      .BTN_LONG(BTN_LONG), .SW_OUT(SW_OUT), .SW_CHANGED(SW_CHANGED)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   // kind: 0 press, 1 release, 2 long, 3 switch change (val = SW_OUT)
   typedef struct {
      int          kind;
      logic [15:0] val;
      int          at;
   } ev_t;
   ev_t sbq[$];

   task automatic expect_ev(input int kind, input logic [15:0] val, input int at);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.at   = at;
      sbq.push_back(e);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   always @(negedge CLK) begin
      logic [15:0] obs;
      logic        hit;
      ev_t         e;
      while (sbq.size() != 0 && sbq[0].at < cyc) begin
         n_cmp++;
         n_fail++;
         $error("FAIL missed_event: kind %0d val %h due cycle %0d, still absent at cycle %0d",
                sbq[0].kind, sbq[0].val, sbq[0].at, cyc);
         void'(sbq.pop_front());
      end
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       begin obs = 16'(BTN_PRESS);   hit = (|BTN_PRESS)   === 1'b1; end
            1:       begin obs = 16'(BTN_RELEASE); hit = (|BTN_RELEASE) === 1'b1; end
            2:       begin obs = 16'(BTN_LONG);    hit = (|BTN_LONG)    === 1'b1; end
            default: begin obs = SW_OUT;           hit = SW_CHANGED     === 1'b1; end
         endcase
         if (hit) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_fail++;
               $error("FAIL unexpected_event: kind %0d val %h at cycle %0d, none expected", k, obs, cyc);
            end else begin
               e = sbq.pop_front();
               n_cmp++;
               assert (k === e.kind && obs === e.val && cyc === e.at) else begin
                  n_fail++;
                  $error("FAIL event: observed kind %0d val %h cycle %0d, expected kind %0d val %h cycle %0d",
                         k, obs, cyc, e.kind, e.val, e.at);
               end
            end
         end
      end
   end

   initial begin
      RST     = 1'b1;
      BTN_RAW = '0;
      SW_RAW  = '0;

      // Reset state, then idle with raw inputs low
      step(3);
      check("rst_level",   32'(BTN_LEVEL),   32'h0);
      check("rst_press",   32'(BTN_PRESS),   32'h0);
      check("rst_release", 32'(BTN_RELEASE), 32'h0);
      check("rst_long",    32'(BTN_LONG),    32'h0);
      check("rst_sw_out",  32'(SW_OUT),      32'h0);
      check("rst_sw_chg",  32'(SW_CHANGED),  32'h0);
      RST = 1'b0;
      step(50);
      check("idle_level",  32'(BTN_LEVEL),   32'h0);
      check("idle_sw_out", 32'(SW_OUT),      32'h0);

      // Clean press and release of BTNC
      BTN_RAW[0] = 1'b1;
      expect_ev(0, 16'h0001, cyc + LAT);
      step(LAT - 1);
      check("b0_level_before", 32'(BTN_LEVEL[0]), 32'h0);
      step(1);
      check("b0_level_pressed", 32'(BTN_LEVEL[0]), 32'h1);
      step(1);
      check("b0_press_width", 32'(BTN_PRESS[0]), 32'h0);
      step(5);
      BTN_RAW[0] = 1'b0;
      expect_ev(1, 16'h0001, cyc + LAT);
      step(LAT - 1);
      check("b0_level_held", 32'(BTN_LEVEL[0]), 32'h1);
      step(1);
      check("b0_level_released", 32'(BTN_LEVEL[0]), 32'h0);
      step(3);

      // Short glitches on BTNL: none may pass while idle or while pressed
      BTN_RAW[2] = 1'b1;
      step(DB - 1);
      BTN_RAW[2] = 1'b0;
      step(10);
      check("b2_glitch_level", 32'(BTN_LEVEL[2]), 32'h0);
      BTN_RAW[2] = 1'b1;
      expect_ev(0, 16'h0004, cyc + LAT);
      step(10);
      BTN_RAW[2] = 1'b0;
      step(DB - 1);
      BTN_RAW[2] = 1'b1;
      step(10);
      check("b2_low_glitch_level", 32'(BTN_LEVEL[2]), 32'h1);
      BTN_RAW[2] = 1'b0;
      expect_ev(1, 16'h0004, cyc + LAT);
      step(10);

      // Switch burst merged into one update
      SW_RAW = 16'hA5A5;
      step(2);
      SW_RAW = 16'hA5A4;
      expect_ev(3, 16'hA5A4, cyc + LAT);
      step(10);
      check("sw_out_merged", 32'(SW_OUT), 32'h0000A5A4);

      // Simultaneous presses and releases on BTNU/BTNR
      BTN_RAW[1] = 1'b1;
      BTN_RAW[3] = 1'b1;
      expect_ev(0, 16'h000A, cyc + LAT);
      step(10);
      check("b13_level", 32'(BTN_LEVEL), 32'h0000000A);
      BTN_RAW[1] = 1'b0;
      BTN_RAW[3] = 1'b0;
      expect_ev(1, 16'h000A, cyc + LAT);
      step(10);

      // Reset while BTND is mid-debounce: no pulse, switches re-debounce from zero
      BTN_RAW[4] = 1'b1;
      step(3);
      RST = 1'b1;
      BTN_RAW[4] = 1'b0;
      step(1);
      check("midrst_sw_out", 32'(SW_OUT),    32'h0);
      check("midrst_level",  32'(BTN_LEVEL), 32'h0);
      RST = 1'b0;
      expect_ev(3, 16'hA5A4, cyc + LAT);
      step(1);
      check("postrst_press", 32'(BTN_PRESS), 32'h0);
      step(15);
      check("postrst_sw_out", 32'(SW_OUT), 32'h0000A5A4);

      // Long hold on BTND
      BTN_RAW[4] = 1'b1;
      expect_ev(0, 16'h0010, cyc + LAT);
`ifdef LONG_PRESS_EN
      expect_ev(2, 16'h0010, cyc + LAT + LONG);
`endif
      step(40);
      check("b4_level_hold", 32'(BTN_LEVEL[4]), 32'h1);
      check("b4_long_now",   32'(BTN_LONG),     32'h0);
      BTN_RAW[4] = 1'b0;
      expect_ev(1, 16'h0010, cyc + LAT);
      step(20);

      check("queue_drained", 32'(sbq.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
